alu_flags_register: RTL and testbench
=====================================

Name: alu_flags_register

Overview:
- Downstream stage of the ALU. Captures the five ALU flag outputs into the architectural flags register.
- Feeds the logical-shift carry back to the ALU as LCarryIn.
- Loads and asserts the flags byte on MainBus for push/pop.
- Produces a registered branch-condition result for the jump logic.

Parameters:
- FLAGS_W, 5, number of architectural flag bits (bits 7:FLAGS_W of the bus byte read as 0).
- COND_W, 4, width of the condition-code select.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- MainBus  inout  8  shared data bus; driven only while FlagsAssert_n=0.
- Flags_0_Overflow, Flags_1_Sign, Flags_2_Zero, Flags_3_CarryA, Flags_4_CarryL  input  1 each  ALU flag results.
- FlagsUpdate  input  1  capture ALU flags this edge (driven from AluActive).
- FlagsLoad_n  input  1  active-low: load flags from MainBus[4:0].
- FlagsAssert_n  input  1  active-low: drive flags byte onto MainBus.
- CondCode  input  4  condition select.
- CondValid  input  1  evaluate CondCode this edge.
- CondTaken  output  1  registered condition result.
- CondTakenValid  output  1  one-cycle strobe qualifying CondTaken.
- LCarryIn  output  1  registered CarryL fed to the ALU.
- FlagsOut  output  5  current flags {CarryL,CarryA,Zero,Sign,Overflow}.
- BusConflict  output  1  sticky error flag.

Behaviour:
- Reset (asynchronous, Reset_n=0): FlagsOut=0, LCarryIn=0, CondTaken=0, CondTakenValid=0, BusConflict=0, MainBus released (Z).
- Bus byte layout: bit0 O, bit1 S, bit2 Z, bit3 CA, bit4 CL, bits7:5 = 0.
- Flags write priority per edge: FlagsLoad_n=0 (bus load) > FlagsUpdate > hold.
- Simultaneous FlagsAssert_n=0 and FlagsLoad_n=0:
  - Assert wins and the bus is driven with the old flags.
  - The load is suppressed.
  - BusConflict sets and stays set until reset.
- Bus drive: MainBus is combinationally driven from the registered flags while FlagsAssert_n=0, otherwise Z. Latency 0 cycles.
- LCarryIn always equals registered CL, so a flags update at edge N is visible to the ALU from cycle N+1.
- Condition evaluation: on an edge with CondValid=1, CondTaken <= f(CondCode, F) and CondTakenValid <= 1; otherwise CondTakenValid <= 0 and CondTaken holds. Latency 1 cycle.
- Bypass for F: if the same edge also writes the flags (load or update), F is the value being written, not the old value. This removes the flag-to-branch hazard.
- Condition codes:
  - 0 O, 1 !O, 2 S, 3 !S, 4 Z, 5 !Z, 6 CA, 7 !CA, 8 CL, 9 !CL
  - A CA|Z, B !(CA|Z), C S^O, D !(S^O)
  - E always 1, F always 0
- Reset mid-operation: all state clears immediately. A pending CondTakenValid is lost and the bus is released.

Optional Feature:
- Macro FLAGS_SHADOW_EN.
- Enabled: adds inputs IntSave and IntRestore and a 5-bit shadow register (reset 0).
  - IntSave=1: shadow <= flags (the write-bypassed value if the flags are written the same edge).
  - IntRestore=1: flags <= shadow, with priority above bus load and FlagsUpdate.
  - IntSave and IntRestore together: flags and shadow swap.
- Disabled: the ports and the shadow register do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg:
  - flag bit-index constants (FLAG_O=0 … FLAG_CL=4).
  - condition-code localparams COND_O … COND_NEVER.
  - FLAGS_W.
- One sub-module, alu_cond_eval: purely combinational, CondCode + 5-bit flags -> taken. Reused by the jump unit.

Test Plan:
- Reset check: Reset_n low with random inputs -> FlagsOut=0, LCarryIn=0, MainBus=Z, CondTakenValid=0. Asynchronous release mid-cycle gives no glitch.
- ALU update: FlagsUpdate=1 with Z=1, CL=1, others 0 -> next cycle FlagsOut=5'b10100 and LCarryIn=1. FlagsAssert_n=0 -> MainBus=8'h14.
- Bus load priority: FlagsLoad_n=0 with MainBus=8'hFF, and FlagsUpdate=1 with all flags 0, same edge -> FlagsOut=5'b11111 (bits 7:5 ignored).
- Conflict: FlagsAssert_n=0 and FlagsLoad_n=0 with flags=5'h03 -> MainBus=8'h03, flags unchanged, BusConflict=1, sticky across 10 idle cycles.
- Bypass branch: flags=0, FlagsUpdate with Z=1 plus CondValid with CondCode=4 on the same edge -> next cycle CondTaken=1, CondTakenValid=1. CondCode=5 on the same stimulus -> 0.
- Shadow (FLAGS_SHADOW_EN):
  - flags=5'h05, IntSave, then update to 5'h00, then IntRestore -> flags=5'h05.
  - IntSave and IntRestore together -> flags and shadow swap.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU flags path: flag bit positions, condition codes, widths.
// Used by alu_flags_register, alu_cond_eval and the jump unit.
package alu_pkg;

  localparam int unsigned FLAGS_W = 5;
  localparam int unsigned COND_W  = 4;
  localparam int unsigned BUS_W   = 8;

  localparam int unsigned FLAG_O  = 0;
  localparam int unsigned FLAG_S  = 1;
  localparam int unsigned FLAG_Z  = 2;
  localparam int unsigned FLAG_CA = 3;
  localparam int unsigned FLAG_CL = 4;

  localparam logic [COND_W-1:0] COND_O      = 4'h0;
  localparam logic [COND_W-1:0] COND_NO     = 4'h1;
  localparam logic [COND_W-1:0] COND_S      = 4'h2;
  localparam logic [COND_W-1:0] COND_NS     = 4'h3;
  localparam logic [COND_W-1:0] COND_Z      = 4'h4;
  localparam logic [COND_W-1:0] COND_NZ     = 4'h5;
  localparam logic [COND_W-1:0] COND_CA     = 4'h6;
  localparam logic [COND_W-1:0] COND_NCA    = 4'h7;
  localparam logic [COND_W-1:0] COND_CL     = 4'h8;
  localparam logic [COND_W-1:0] COND_NCL    = 4'h9;
  localparam logic [COND_W-1:0] COND_BE     = 4'hA;
  localparam logic [COND_W-1:0] COND_A      = 4'hB;
  localparam logic [COND_W-1:0] COND_LT     = 4'hC;
  localparam logic [COND_W-1:0] COND_GE     = 4'hD;
  localparam logic [COND_W-1:0] COND_ALWAYS = 4'hE;
  localparam logic [COND_W-1:0] COND_NEVER  = 4'hF;

  // Source selected for the next flags value.
  typedef enum logic [1:0] {
    SrcHold,
    SrcUpdate,
    SrcLoad,
    SrcRestore
  } flags_src_e;

  // Bus byte: architectural flags in the low bits, upper bits read as zero.
  function automatic logic [BUS_W-1:0] flags_to_bus(input logic [FLAGS_W-1:0] f);
    return {{(BUS_W - FLAGS_W){1'b0}}, f};
  endfunction

endpackage

// File: rtl/alu_cond_eval.sv
// Combinational branch-condition evaluator: condition code plus flags gives taken.
// Shared with the jump unit, so it holds no state.
module alu_cond_eval
  import alu_pkg::*;
(
  input  logic [COND_W-1:0]  cond_code,
  input  logic [FLAGS_W-1:0] flags,
  output logic               taken
);

  logic f_o, f_s, f_z, f_ca, f_cl;

  assign f_o  = flags[FLAG_O];
  assign f_s  = flags[FLAG_S];
  assign f_z  = flags[FLAG_Z];
  assign f_ca = flags[FLAG_CA];
  assign f_cl = flags[FLAG_CL];

  always_comb begin
    taken = 1'b0;
    unique case (cond_code)
      COND_O:      taken = f_o;
      COND_NO:     taken = ~f_o;
      COND_S:      taken = f_s;
      COND_NS:     taken = ~f_s;
      COND_Z:      taken = f_z;
      COND_NZ:     taken = ~f_z;
      COND_CA:     taken = f_ca;
      COND_NCA:    taken = ~f_ca;
      COND_CL:     taken = f_cl;
      COND_NCL:    taken = ~f_cl;
      COND_BE:     taken = f_ca | f_z;
      COND_A:      taken = ~(f_ca | f_z);
      COND_LT:     taken = f_s ^ f_o;
      COND_GE:     taken = ~(f_s ^ f_o);
      COND_ALWAYS: taken = 1'b1;
      COND_NEVER:  taken = 1'b0;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_flags_register.sv
// Architectural flags register behind the ALU: capture, bus push/pop, branch evaluation.
// Optional interrupt shadow copy of the flags is built when FLAGS_SHADOW_EN is defined.
module alu_flags_register
  import alu_pkg::*;
(
  input  logic               Clock,
  input  logic               Reset_n,
  inout  wire  [BUS_W-1:0]   MainBus,
  input  logic               Flags_0_Overflow,
  input  logic               Flags_1_Sign,
  input  logic               Flags_2_Zero,
  input  logic               Flags_3_CarryA,
  input  logic               Flags_4_CarryL,
  input  logic               FlagsUpdate,
  input  logic               FlagsLoad_n,
  input  logic               FlagsAssert_n,
`ifdef FLAGS_SHADOW_EN
  input  logic               IntSave,
  input  logic               IntRestore,
`endif
  input  logic [COND_W-1:0]  CondCode,
  input  logic               CondValid,
  output logic               CondTaken,
  output logic               CondTakenValid,
  output logic               LCarryIn,
  output logic [FLAGS_W-1:0] FlagsOut,
  output logic               BusConflict
);

  logic [FLAGS_W-1:0] flags_q, flags_d;
  logic [FLAGS_W-1:0] alu_flags;
  logic [FLAGS_W-1:0] bus_flags;
  flags_src_e         flags_src;
  logic               bus_load;
  logic               bus_drive;
  logic               conflict;
  logic               cond_taken_q, cond_taken_d;
  logic               cond_valid_q;
  logic               conflict_q;
  logic               eval_taken;
  logic               unused_bus_hi;

  assign alu_flags = {Flags_4_CarryL, Flags_3_CarryA, Flags_2_Zero, Flags_1_Sign,
                      Flags_0_Overflow};

  assign bus_flags     = MainBus[FLAGS_W-1:0];
  assign unused_bus_hi = ^MainBus[BUS_W-1:FLAGS_W];

  // An assert on the same edge as a load owns the bus; the load would read our own drive.
  assign conflict  = ~FlagsAssert_n & ~FlagsLoad_n;
  assign bus_load  = ~FlagsLoad_n & FlagsAssert_n;
  assign bus_drive = ~FlagsAssert_n & Reset_n;

  assign MainBus = bus_drive ? flags_to_bus(flags_q) : {BUS_W{1'bz}};

`ifdef FLAGS_SHADOW_EN
  logic [FLAGS_W-1:0] shadow_q, shadow_d;
`endif

  always_comb begin
    flags_src = SrcHold;
    if (bus_load) begin
      flags_src = SrcLoad;
    end else if (FlagsUpdate) begin
      flags_src = SrcUpdate;
    end
`ifdef FLAGS_SHADOW_EN
    if (IntRestore) begin
      flags_src = SrcRestore;
    end
`endif
  end

  always_comb begin
    flags_d = flags_q;
    unique case (flags_src)
      SrcLoad:    flags_d = bus_flags;
      SrcUpdate:  flags_d = alu_flags;
`ifdef FLAGS_SHADOW_EN
      SrcRestore: flags_d = shadow_q;
`endif
      default:    flags_d = flags_q;
    endcase
  end

`ifdef FLAGS_SHADOW_EN
  // Save+restore together is a swap, so the shadow must take the pre-edge flags.
  always_comb begin
    shadow_d = shadow_q;
    if (IntSave) begin
      shadow_d = IntRestore ? flags_q : flags_d;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end
`endif

  // Evaluate on the flags being written this edge to avoid a flag-to-branch hazard.
  alu_cond_eval u_cond_eval (
    .cond_code (CondCode),
    .flags     (flags_d),
    .taken     (eval_taken)
  );

  always_comb begin
    cond_taken_d = cond_taken_q;
    if (CondValid) begin
      cond_taken_d = eval_taken;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      flags_q      <= '0;
      cond_taken_q <= 1'b0;
      cond_valid_q <= 1'b0;
      conflict_q   <= 1'b0;
    end else begin
      flags_q      <= flags_d;
      cond_taken_q <= cond_taken_d;
      cond_valid_q <= CondValid;
      conflict_q   <= conflict_q | conflict;
    end
  end

  assign FlagsOut       = flags_q;
  assign LCarryIn       = flags_q[FLAG_CL];
  assign CondTaken      = cond_taken_q;
  assign CondTakenValid = cond_valid_q;
  assign BusConflict    = conflict_q;

endmodule

// File: tb/tb_alu_flags_register.sv
// Directed self-checking bench for alu_flags_register; shadow steps run when FLAGS_SHADOW_EN is set.
module tb_alu_flags_register;
  import alu_pkg::*;

  logic       Clock = 1'b0;
  logic       Reset_n;
  wire  [7:0] MainBus;
  logic       f_o, f_s, f_z, f_ca, f_cl;
  logic       FlagsUpdate, FlagsLoad_n, FlagsAssert_n;
  logic [3:0] CondCode;
  logic       CondValid;
  logic       CondTaken, CondTakenValid, LCarryIn, BusConflict;
  logic [4:0] FlagsOut;
`ifdef FLAGS_SHADOW_EN
  logic       IntSave, IntRestore;
`endif

  logic [7:0] bus_drv;
  logic       bus_en;
  assign MainBus = bus_en ? bus_drv : 8'bz;

  int tests = 0;
  int fails = 0;

  always #5 Clock = ~Clock;

  alu_flags_register dut (
    .Clock            (Clock),
    .Reset_n          (Reset_n),
    .MainBus          (MainBus),
    .Flags_0_Overflow (f_o),
    .Flags_1_Sign     (f_s),
    .Flags_2_Zero     (f_z),
    .Flags_3_CarryA   (f_ca),
    .Flags_4_CarryL   (f_cl),
    .FlagsUpdate      (FlagsUpdate),
    .FlagsLoad_n      (FlagsLoad_n),
    .FlagsAssert_n    (FlagsAssert_n),
`ifdef FLAGS_SHADOW_EN
    .IntSave          (IntSave),
    .IntRestore       (IntRestore),
`endif
    .CondCode         (CondCode),
    .CondValid        (CondValid),
    .CondTaken        (CondTaken),
    .CondTakenValid   (CondTakenValid),
    .LCarryIn         (LCarryIn),
    .FlagsOut         (FlagsOut),
    .BusConflict      (BusConflict)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_alu(input logic [4:0] v);
    {f_cl, f_ca, f_z, f_s, f_o} = v;
  endtask

  task automatic load_bus(input logic [7:0] v);
    bus_en = 1'b1;
    bus_drv = v;
    FlagsLoad_n = 1'b0;
    tick();
    bus_en = 1'b0;
    FlagsLoad_n = 1'b1;
  endtask

  task automatic cond_sweep(input string tag, input logic [15:0] exp_vec);
    for (int i = 0; i < 16; i++) begin
      CondCode = 4'(i);
      CondValid = 1'b1;
      tick();
      CondValid = 1'b0;
      chk($sformatf("%s_code%0h", tag, i), {7'b0, CondTaken}, {7'b0, exp_vec[i]});
      chk($sformatf("%s_valid%0h", tag, i), {7'b0, CondTakenValid}, 8'h01);
    end
  endtask

  initial begin
    // Reset with busy inputs
    Reset_n = 1'b0;
    set_alu(5'b11111);
    FlagsUpdate = 1'b1;
    FlagsLoad_n = 1'b0;
    FlagsAssert_n = 1'b0;
    CondCode = 4'hE;
    CondValid = 1'b1;
    bus_en = 1'b1;
    bus_drv = 8'h5A;
`ifdef FLAGS_SHADOW_EN
    IntSave = 1'b1;
    IntRestore = 1'b1;
`endif
    tick();
    tick();
    chk("rst_flags", {3'b0, FlagsOut}, 8'h00);
    chk("rst_lcarry", {7'b0, LCarryIn}, 8'h00);
    chk("rst_cvalid", {7'b0, CondTakenValid}, 8'h00);
    chk("rst_ctaken", {7'b0, CondTaken}, 8'h00);
    chk("rst_conflict", {7'b0, BusConflict}, 8'h00);
    chk("rst_bus_released", MainBus, 8'h5A);

    // Idle inputs, then release reset mid-cycle
    set_alu(5'b00000);
    FlagsUpdate = 1'b0;
    FlagsLoad_n = 1'b1;
    FlagsAssert_n = 1'b1;
    CondValid = 1'b0;
    bus_en = 1'b0;
`ifdef FLAGS_SHADOW_EN
    IntSave = 1'b0;
    IntRestore = 1'b0;
`endif
    #3 Reset_n = 1'b1;
    #1 chk("rel_flags", {3'b0, FlagsOut}, 8'h00);
    tick();
    chk("rel_flags_edge", {3'b0, FlagsOut}, 8'h00);
    chk("rel_cvalid_edge", {7'b0, CondTakenValid}, 8'h00);

    // ALU update: Z and CL
    set_alu(5'b10100);
    FlagsUpdate = 1'b1;
    tick();
    FlagsUpdate = 1'b0;
    set_alu(5'b00000);
    chk("upd_flags", {3'b0, FlagsOut}, 8'h14);
    chk("upd_lcarry", {7'b0, LCarryIn}, 8'h01);
    FlagsAssert_n = 1'b0;
    #1 chk("upd_bus", MainBus, 8'h14);
    FlagsAssert_n = 1'b1;
    tick();
    chk("upd_hold", {3'b0, FlagsOut}, 8'h14);

    // ALU update: O, S, CA
    set_alu(5'b01011);
    FlagsUpdate = 1'b1;
    tick();
    FlagsUpdate = 1'b0;
    chk("upd2_flags", {3'b0, FlagsOut}, 8'h0B);
    chk("upd2_lcarry", {7'b0, LCarryIn}, 8'h00);

    // Bus load beats FlagsUpdate; upper bus bits ignored
    set_alu(5'b00000);
    FlagsUpdate = 1'b1;
    load_bus(8'hFF);
    FlagsUpdate = 1'b0;
    chk("load_prio", {3'b0, FlagsOut}, 8'h1F);
    chk("load_lcarry", {7'b0, LCarryIn}, 8'h01);
    chk("load_no_conflict", {7'b0, BusConflict}, 8'h00);

    // Assert + load conflict
    load_bus(8'h03);
    chk("cf_pre", {3'b0, FlagsOut}, 8'h03);
    FlagsAssert_n = 1'b0;
    FlagsLoad_n = 1'b0;
    #1 chk("cf_bus", MainBus, 8'h03);
    tick();
    FlagsAssert_n = 1'b1;
    FlagsLoad_n = 1'b1;
    chk("cf_flags", {3'b0, FlagsOut}, 8'h03);
    chk("cf_set", {7'b0, BusConflict}, 8'h01);
    for (int i = 0; i < 10; i++) tick();
    chk("cf_sticky", {7'b0, BusConflict}, 8'h01);

    // Condition codes on held flags
    load_bus(8'h05);
    cond_sweep("cc05", 16'h5699);
    load_bus(8'h1A);
    cond_sweep("cc1a", 16'h5566);
    load_bus(8'h00);
    cond_sweep("cc00", 16'h6AAA);
    tick();
    chk("cv_drop", {7'b0, CondTakenValid}, 8'h00);
    chk("ct_hold", {7'b0, CondTaken}, 8'h00);

    // Bypass: update Z=1 with CondCode Z on the same edge
    set_alu(5'b00100);
    FlagsUpdate = 1'b1;
    CondCode = 4'h4;
    CondValid = 1'b1;
    tick();
    FlagsUpdate = 1'b0;
    CondValid = 1'b0;
    chk("byp_z_taken", {7'b0, CondTaken}, 8'h01);
    chk("byp_z_valid", {7'b0, CondTakenValid}, 8'h01);
    tick();
    chk("byp_z_vdrop", {7'b0, CondTakenValid}, 8'h00);
    chk("byp_z_hold", {7'b0, CondTaken}, 8'h01);
    load_bus(8'h00);
    FlagsUpdate = 1'b1;
    CondCode = 4'h5;
    CondValid = 1'b1;
    tick();
    FlagsUpdate = 1'b0;
    CondValid = 1'b0;
    chk("byp_nz_taken", {7'b0, CondTaken}, 8'h00);
    chk("byp_nz_valid", {7'b0, CondTakenValid}, 8'h01);

    // Bypass through a bus load: load CL=1 and test CL
    bus_en = 1'b1;
    bus_drv = 8'h10;
    FlagsLoad_n = 1'b0;
    CondCode = 4'h8;
    CondValid = 1'b1;
    tick();
    bus_en = 1'b0;
    FlagsLoad_n = 1'b1;
    CondValid = 1'b0;
    chk("byp_load_cl", {7'b0, CondTaken}, 8'h01);

    // Reset mid-operation
    load_bus(8'h0F);
    CondCode = 4'hE;
    CondValid = 1'b1;
    tick();
    CondValid = 1'b0;
    chk("mid_pre_valid", {7'b0, CondTakenValid}, 8'h01);
    #2 Reset_n = 1'b0;
    #1;
    chk("mid_flags", {3'b0, FlagsOut}, 8'h00);
    chk("mid_cvalid", {7'b0, CondTakenValid}, 8'h00);
    chk("mid_ctaken", {7'b0, CondTaken}, 8'h00);
    chk("mid_conflict", {7'b0, BusConflict}, 8'h00);
    #1 Reset_n = 1'b1;
    tick();

`ifdef FLAGS_SHADOW_EN
    // Save, clobber, restore
    load_bus(8'h05);
    IntSave = 1'b1;
    tick();
    IntSave = 1'b0;
    set_alu(5'b00000);
    FlagsUpdate = 1'b1;
    tick();
    FlagsUpdate = 1'b0;
    chk("sh_clobber", {3'b0, FlagsOut}, 8'h00);
    IntRestore = 1'b1;
    tick();
    IntRestore = 1'b0;
    chk("sh_restore", {3'b0, FlagsOut}, 8'h05);

    // Swap: flags 0A, shadow 05
    load_bus(8'h0A);
    IntSave = 1'b1;
    IntRestore = 1'b1;
    tick();
    IntSave = 1'b0;
    IntRestore = 1'b0;
    chk("sh_swap_flags", {3'b0, FlagsOut}, 8'h05);
    IntRestore = 1'b1;
    tick();
    IntRestore = 1'b0;
    chk("sh_swap_shadow", {3'b0, FlagsOut}, 8'h0A);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
